// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Holds the 3-bit state encoding used by the FSM and the bench.
package fetch_sequencer_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_MEM   = 3'd2;
    localparam logic [2:0] ST_IR    = 3'd3;
    localparam logic [2:0] ST_VALID = 3'd4;
    localparam logic [2:0] ST_JUMP  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ADDR  = ST_ADDR,
        S_MEM   = ST_MEM,
        S_IR    = ST_IR,
        S_VALID = ST_VALID,
        S_JUMP  = ST_JUMP
    } fs_state_t;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Watchdog for the MEM wait: counts cycles without ack.
// Ports: clk, clr (sync reset), i_clear, i_enable, o_expired.
module fetch_timeout_counter
    import fetch_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic clr,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clr || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Last waiting cycle; the FSM leaves MEM here, so no wrap.
    assign o_expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/jump control sequencer driving PC, MAR, IR strobes and mem req.
// Ports: clk, clr, fetch_start, jmp_req, jmp_target, mem_ack, instr_taken
// in; PC/MAR/IR strobes, mem_req, bus_out/bus_oe, instr_valid, busy,
// fetch_err out. All outputs are decodes of registered state.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  fetch_start,
    input  logic                  jmp_req,
    input  logic [DATA_WIDTH-1:0] jmp_target,
    input  logic                  mem_ack,
    input  logic                  instr_taken,
    output logic                  pc_read,
    output logic                  pc_notWrite,
    output logic                  pc_inc,
    output logic                  mar_load,
    output logic                  ir_load,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  bus_oe,
    output logic                  instr_valid,
    output logic                  busy,
    output logic                  fetch_err
);

    fs_state_t             r_state;
    fs_state_t             w_next;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_bus;
    logic                  w_expired;
    logic                  w_in_mem;
    logic                  w_timeout;
    logic                  w_take_jump;

    assign w_in_mem    = (r_state == S_MEM);
    assign w_timeout   = w_in_mem && !mem_ack && w_expired;
    assign w_take_jump = (r_state == S_IDLE) && jmp_req;

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .clr       (clr),
        .i_clear   (!w_in_mem),
        .i_enable  (w_in_mem && !mem_ack),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
            r_bus   <= '0;
        end else begin
            r_state <= w_next;
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (w_take_jump) begin
                r_err <= 1'b0;
            end
            // Target is captured so bus_out stays a pure state decode.
            r_bus <= w_take_jump ? jmp_target : '0;
        end
    end

    always_comb begin
        w_next      = r_state;
        pc_read     = 1'b0;
        pc_notWrite = 1'b1;
        pc_inc      = 1'b0;
        mar_load    = 1'b0;
        ir_load     = 1'b0;
        mem_req     = 1'b0;
        bus_oe      = 1'b0;
        instr_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (jmp_req) begin
                    w_next = S_JUMP;
                end else if (fetch_start && !r_err) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                pc_read  = 1'b1;
                mar_load = 1'b1;
                w_next   = S_MEM;
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_next = S_IR;
                end else if (w_expired) begin
                    w_next = S_IDLE;
                end
            end
            S_IR: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                w_next  = S_VALID;
            end
            S_VALID: begin
                instr_valid = 1'b1;
                if (instr_taken) begin
                    w_next = S_IDLE;
                end
            end
            S_JUMP: begin
                bus_oe      = 1'b1;
                pc_notWrite = 1'b0;
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus_out   = r_bus;
    assign busy      = (r_state != S_IDLE);
    assign fetch_err = r_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a small PC/MAR/IR/memory
// datapath model sharing a muxed data bus.
module tb_fetch_sequencer;

    localparam int DW  = 16;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          fetch_start = 1'b0;
    logic          jmp_req = 1'b0;
    logic [DW-1:0] jmp_target = '0;
    logic          mem_ack = 1'b0;
    logic          instr_taken = 1'b0;
    logic          pc_read, pc_notWrite, pc_inc, mar_load, ir_load;
    logic          mem_req, bus_oe, instr_valid, busy, fetch_err;
    logic [DW-1:0] bus_out;

    logic [DW-1:0] pc = '0;
    logic [DW-1:0] mar = '0;
    logic [DW-1:0] ir = '0;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] pc_init = '0;
    logic          pc_set = 1'b0;
    logic [DW-1:0] data_bus;

    typedef struct {
        byte           kind;
        logic [DW-1:0] val;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .fetch_start (fetch_start),
        .jmp_req     (jmp_req),
        .jmp_target  (jmp_target),
        .mem_ack     (mem_ack),
        .instr_taken (instr_taken),
        .pc_read     (pc_read),
        .pc_notWrite (pc_notWrite),
        .pc_inc      (pc_inc),
        .mar_load    (mar_load),
        .ir_load     (ir_load),
        .mem_req     (mem_req),
        .bus_out     (bus_out),
        .bus_oe      (bus_oe),
        .instr_valid (instr_valid),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    // Resolved bus: this block, else PC, else memory holding its data.
    assign data_bus = bus_oe  ? bus_out :
                      pc_read ? pc : mem_data;

    always @(posedge clk) begin
        if (pc_set) pc <= pc_init;
        else if (!pc_notWrite) pc <= data_bus;
        else if (pc_inc) pc <= pc + 16'd1;
        if (mar_load) mar <= data_bus;
        if (ir_load) ir <= data_bus;
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input byte k, input logic [DW-1:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic pop(input byte k, input logic [DW-1:0] v);
        exp_t e;
        if (q.size() == 0) begin
            check("unexpected_event", {24'd0, k}, 32'd0);
        end else begin
            e = q.pop_front();
            check("event_kind", {24'd0, k}, {24'd0, e.kind});
            check("event_value", {16'd0, v}, {16'd0, e.val});
        end
    endtask

    // Monitor: pops the scoreboard on every observable DUT event.
    always @(negedge clk) begin
        if (!clr) begin
            check("bus_exclusion", {31'd0, pc_read & bus_oe}, 32'd0);
            if (mar_load) pop("M", data_bus);
            if (ir_load) pop("I", data_bus);
            if (!pc_notWrite) pop("J", data_bus);
            if (instr_valid && !prev_v) pop("V", pc);
            if (fetch_err && !prev_e) pop("E", '0);
        end
        prev_v <= instr_valid;
        prev_e <= fetch_err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        pc_set  = 1'b1;
        pc_init = 16'hDEAD;
        tick();
        tick();
        pc_set = 1'b0;
        clr    = 1'b0;
        check("rst_notWrite", {31'd0, pc_notWrite}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_bus", {16'd0, bus_out}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);

        // Fetch with ack on second MEM cycle.
        push("M", 16'hDEAD);
        push("I", 16'h1234);
        push("V", 16'hDEAE);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("f_addr_pc_read", {31'd0, pc_read}, 32'd1);
        tick();
        check("f_mem1_req", {31'd0, mem_req}, 32'd1);
        tick();
        mem_ack  = 1'b1;
        mem_data = 16'h1234;
        tick();
        mem_ack = 1'b0;
        check("f_n3_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("f_n4_valid", {31'd0, instr_valid}, 32'd1);
        check("f_mar", {16'd0, mar}, 32'h0000DEAD);
        check("f_ir", {16'd0, ir}, 32'h00001234);
        check("f_pc", {16'd0, pc}, 32'h0000DEAE);
        tick();
        tick();
        check("f_hold_valid", {31'd0, instr_valid}, 32'd1);
        instr_taken = 1'b1;
        tick();
        instr_taken = 1'b0;
        check("f_taken_valid", {31'd0, instr_valid}, 32'd0);
        check("f_taken_busy", {31'd0, busy}, 32'd0);

        // Jump and fetch together: jump first, then fetch from target.
        push("J", 16'hBEEF);
        push("M", 16'hBEEF);
        push("I", 16'hA5A5);
        push("V", 16'hBEF0);
        jmp_req     = 1'b1;
        jmp_target  = 16'hBEEF;
        fetch_start = 1'b1;
        tick();
        jmp_req = 1'b0;
        check("j_bus_oe", {31'd0, bus_oe}, 32'd1);
        check("j_notWrite", {31'd0, pc_notWrite}, 32'd0);
        check("j_bus_out", {16'd0, bus_out}, 32'h0000BEEF);
        tick();
        check("j_pc", {16'd0, pc}, 32'h0000BEEF);
        check("j_bus_oe_off", {31'd0, bus_oe}, 32'd0);
        check("j_bus_out_off", {16'd0, bus_out}, 32'd0);
        tick();
        fetch_start = 1'b0;
        tick();
        mem_ack  = 1'b1;
        mem_data = 16'hA5A5;
        tick();
        mem_ack = 1'b0;
        tick();
        check("p_valid", {31'd0, instr_valid}, 32'd1);
        check("p_mar", {16'd0, mar}, 32'h0000BEEF);
        instr_taken = 1'b1;
        tick();
        instr_taken = 1'b0;

        // Plain jump.
        push("J", 16'h0F00);
        jmp_req    = 1'b1;
        jmp_target = 16'h0F00;
        tick();
        jmp_req = 1'b0;
        tick();
        check("j2_pc", {16'd0, pc}, 32'h00000F00);

        // Timeout: no ack ever.
        push("M", 16'h0F00);
        push("E", 16'h0000);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        cnt = 0;
        while (mem_req && cnt < 100) begin
            cnt++;
            tick();
        end
        check("t_req_cycles", cnt, TMO);
        check("t_err", {31'd0, fetch_err}, 32'd1);
        check("t_busy", {31'd0, busy}, 32'd0);
        fetch_start = 1'b1;
        tick();
        tick();
        fetch_start = 1'b0;
        check("t_blocked", {31'd0, busy}, 32'd0);

        // Jump clears the fault.
        push("J", 16'h0123);
        jmp_req    = 1'b1;
        jmp_target = 16'h0123;
        tick();
        jmp_req = 1'b0;
        check("t_err_clear", {31'd0, fetch_err}, 32'd0);
        tick();

        // Reset mid-MEM.
        push("M", 16'h0123);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        tick();
        check("r_in_mem", {31'd0, mem_req}, 32'd1);
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        check("r_notWrite", {31'd0, pc_notWrite}, 32'd1);
        check("r_mem_req", {31'd0, mem_req}, 32'd0);
        check("r_busy", {31'd0, busy}, 32'd0);
        tick();
        check("r_still_idle", {31'd0, busy}, 32'd0);
        tick();
        check("sb_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
